// File: rtl/imem_loader.sv
// imem_loader: buffers the debug program stream in a small FIFO, writes it into
// instruction memory under back-pressure, and releases the core once the image is in.
module imem_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              dbg_sig,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_instr,
  input  logic              dbg_start,
  input  logic              imem_wready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_start,
  output logic [CNT_W-1:0]  load_count,
  output logic [31:0]       checksum,
  output logic              load_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [31:0]       fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  load_count_q, load_count_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              load_err_q, load_err_d;

  logic empty, full, in_range, push, pop, drop, load_start;

  // Push/pop qualification; a full FIFO still accepts a word when the head leaves the same cycle
  always_comb begin
    empty      = (occ_q == '0);
    full       = (occ_q == OCC_FULL);
    in_range   = (dbg_addr[31:ADDR_W] == '0);
    pop        = !empty && imem_wready;
    push       = dbg_sig && in_range && (!full || pop);
    drop       = dbg_sig && !push;
    load_start = dbg_sig && ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ERR));
  end

  // FIFO pointer/occupancy and load statistics next-state; a new load clears stats first
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    load_count_d = load_start ? '0 : load_count_q;
    checksum_d   = load_start ? '0 : checksum_q;
    load_err_d   = (load_start ? 1'b0 : load_err_q) | drop;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (pop) begin
      if (!(&load_count_d)) load_count_d = load_count_d + CNT_W'(1);
      checksum_d = checksum_d + fifo_data_q[rd_ptr_q];
    end
  end

  // FIFO storage, pointers and statistics registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      load_count_q <= '0;
      checksum_q   <= '0;
      load_err_q   <= 1'b0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= dbg_addr[ADDR_W-1:0];
        fifo_data_q[wr_ptr_q] <= dbg_instr;
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      load_count_q <= load_count_d;
      checksum_q   <= checksum_d;
      load_err_q   <= load_err_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a fresh word always (re)enters LOAD, the core is released only once drained
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: if (dbg_sig) state_d = ST_LOAD;
      ST_LOAD:                 if (!dbg_sig) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (dbg_sig)                          state_d = ST_LOAD;
        else if (empty && !pop && dbg_start)  state_d = load_err_q ? ST_ERR : ST_RUN;
      end
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Outputs: memory write port from FIFO head, core release from state
  always_comb begin
    imem_we    = 1'b0;
    imem_waddr = fifo_addr_q[rd_ptr_q];
    imem_wdata = fifo_data_q[rd_ptr_q];
    core_start = 1'b0;
    if (pop)               imem_we    = 1'b1;
    if (state_q == ST_RUN) core_start = 1'b1;
  end

  assign load_count = load_count_q;
  assign checksum   = checksum_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams into imem_loader; expected memory writes are queued
// at stimulus time and a negedge monitor pops/compares each write the DUT performs.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              nrst;
  logic              dbg_sig;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_instr;
  logic              dbg_start;
  logic              imem_wready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_start;
  logic [CNT_W-1:0]  load_count;
  logic [31:0]       checksum;
  logic              load_err;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst),
    .dbg_sig(dbg_sig), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr), .dbg_start(dbg_start),
    .imem_wready(imem_wready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_start(core_start), .load_count(load_count),
    .checksum(checksum), .load_err(load_err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_sum;
  int          exp_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (nrst && imem_we) begin
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        check("waddr", 32'(imem_waddr), 32'(e.addr));
        check("wdata", imem_wdata, e.data);
      end
      check("core_idle_during_write", 32'(core_start), 32'd0);
    end
  end

  task automatic step(input logic sig, input logic [31:0] a, input logic [31:0] d,
                      input logic wr, input logic st);
    dbg_sig     = sig;
    dbg_addr    = a;
    dbg_instr   = d;
    imem_wready = wr;
    dbg_start   = st;
    @(posedge clk);
    #1;
  endtask

  task automatic new_load();
    exp_sum = 32'd0;
    exp_cnt = 0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic wr, input logic ok);
    if (ok) begin
      wr_t e;
      e.addr = a[ADDR_W-1:0];
      e.data = d;
      sb.push_back(e);
      exp_sum = exp_sum + d;
      exp_cnt++;
    end
    step(1'b1, a, d, wr, 1'b0);
  endtask

  // Idle the stream with dbg_start high until the core is released or the budget runs out
  task automatic drain_to_run(input bit toggle, input int max, output int n);
    n = 0;
    while (!core_start && n < max) begin
      step(1'b0, 32'd0, 32'd0, toggle ? ~imem_wready : 1'b1, 1'b1);
      n++;
    end
  endtask

  task automatic drain_fixed(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
  endtask

  task automatic check_final(input string tag, input logic cs, input logic err);
    check({tag, "_all_written"}, 32'(sb.size()), 32'd0);
    check({tag, "_core_start"}, 32'(core_start), 32'(cs));
    check({tag, "_load_err"}, 32'(load_err), 32'(err));
    check({tag, "_load_count"}, 32'(load_count), 32'(exp_cnt));
    check({tag, "_checksum"}, checksum, exp_sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nrst = 1'b0; dbg_sig = 1'b0; dbg_addr = '0; dbg_instr = '0;
    dbg_start = 1'b0; imem_wready = 1'b0;
    new_load();
    #1;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // 1: clean 15-word image, full-speed memory
    new_load();
    for (int i = 0; i < 15; i++) send(32'(i), 32'h1357_0000 + 32'(i) * 32'h1111, 1'b1, 1'b1);
    drain_to_run(1'b0, 10, n);
    check("t1_start_latency", 32'(n <= 2), 32'd1);
    check_final("t1", 1'b1, 1'b0);

    // 2: memory stalled for 6 cycles, words 4 and 5 (0-based) overflow the 4-deep FIFO
    new_load();
    for (int i = 0; i < 8; i++)
      send(32'(16 + i), 32'hC0DE_0000 + 32'(i), (i >= 6) ? 1'b1 : 1'b0, (i == 4 || i == 5) ? 1'b0 : 1'b1);
    drain_fixed(12);
    check_final("t2", 1'b0, 1'b1);

    // 3: address just past the top of memory is dropped, the top word itself is written
    new_load();
    send(32'h0000_03FF, 32'hDEAD_BEEF, 1'b1, 1'b1);
    send(32'h0000_0400, 32'h0BAD_0BAD, 1'b1, 1'b0);
    send(32'h0000_03FE, 32'hFEED_F00D, 1'b1, 1'b1);
    drain_fixed(8);
    check_final("t3", 1'b0, 1'b1);

    // 4: memory ready every other cycle, words every other cycle; nothing lost
    new_load();
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) send(32'(100 + c / 2), 32'h4000_0000 + 32'(c) * 32'h0001_0003, 1'b0, 1'b1);
      else            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    drain_to_run(1'b1, 20, n);
    check("t4_run_reached", 32'(n < 20), 32'd1);
    check_final("t4", 1'b1, 1'b0);

    // 5: re-load from RUN; core drops on the first word edge and counters restart
    new_load();
    send(32'd7, 32'h0000_0007, 1'b1, 1'b1);
    check("t5_core_drop", 32'(core_start), 32'd0);
    check("t5_count_restart", 32'(load_count), 32'd0);
    check("t5_cksum_restart", checksum, 32'd0);
    send(32'd8, 32'h8000_0000, 1'b1, 1'b1);
    send(32'd9, 32'h8000_0001, 1'b1, 1'b1);
    drain_to_run(1'b0, 10, n);
    check_final("t5", 1'b1, 1'b0);

    // 6: reset while 3 words are buffered; none of them may be written afterwards
    new_load();
    send(32'd20, 32'h6666_0001, 1'b0, 1'b1);
    send(32'd21, 32'h6666_0002, 1'b0, 1'b1);
    send(32'd22, 32'h6666_0003, 1'b0, 1'b1);
    dbg_sig = 1'b0;
    imem_wready = 1'b1;
    #1;
    check("t6_pre_reset_we", 32'(imem_we), 32'd1);
    nrst = 1'b0;
    sb.delete();
    new_load();
    #1;
    check("t6_rst_we", 32'(imem_we), 32'd0);
    check("t6_rst_waddr", 32'(imem_waddr), 32'd0);
    check("t6_rst_wdata", imem_wdata, 32'd0);
    check("t6_rst_core_start", 32'(core_start), 32'd0);
    check("t6_rst_load_count", 32'(load_count), 32'd0);
    check("t6_rst_checksum", checksum, 32'd0);
    check("t6_rst_load_err", 32'(load_err), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    drain_fixed(6);
    check("t6_no_replay_count", 32'(load_count), 32'd0);
    check("t6_core_idle", 32'(core_start), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
